// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Combinational fetch-side lookup, Execute-side resolve/mispredict, one-cycle update latency.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            ResolveE,
    input  logic            JumpE,
    input  logic [XLEN-1:0] PCE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            MispredictE,
    output logic [XLEN-1:0] CorrectPCE,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MissCnt
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic [IDXW-1:0] idx_f, idx_e;
    logic [TAGW-1:0] tag_f, tag_e;
    logic            hit_f, hit_e;
    logic            taken_e;
    logic            upd_en;
    logic [1:0]      ctr_d;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    // Fetch-side lookup
    assign idx_f = PCF[IDXW+1:2];
    assign tag_f = PCF[XLEN-1:IDXW+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    always_comb begin
        PredTakenF  = 1'b0;
        PredTargetF = PCF + XLEN'(4);
        if (hit_f) begin
            PredTakenF  = ctr_q[idx_f][1];
            PredTargetF = target_q[idx_f];
        end
    end

    // Execute-side resolve
    assign idx_e   = PCE[IDXW+1:2];
    assign tag_e   = PCE[XLEN-1:IDXW+2];
    assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign taken_e = TakenE | JumpE;

    assign MispredictE = ResolveE &&
                         ((TakenE != PredTakenE) ||
                          (TakenE && PredTakenE && (TargetE != PredTargetE)));
    assign CorrectPCE  = TakenE ? TargetE : PCE + XLEN'(4);

    // A not-taken branch that misses leaves the BTB untouched; everything else writes the entry.
    assign upd_en = ResolveE && (hit_e || taken_e);

    always_comb begin
        ctr_d = ctr_q[idx_e];
        if (!hit_e) begin
            ctr_d = JumpE ? 2'b11 : 2'b10;
        end else if (JumpE) begin
            ctr_d = 2'b11;
        end else if (TakenE) begin
            if (ctr_q[idx_e] != 2'b11) ctr_d = ctr_q[idx_e] + 2'd1;
        end else begin
            if (ctr_q[idx_e] != 2'b00) ctr_d = ctr_q[idx_e] - 2'd1;
        end
    end

    assign branch_cnt_d = branch_cnt_q + (ResolveE ? 32'd1 : 32'd0);
    assign miss_cnt_d   = miss_cnt_q + (MispredictE ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (upd_en) begin
                valid_q[idx_e] <= 1'b1;
                ctr_q[idx_e]   <= ctr_d;
            end
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // NOTE: tag/target arrays are not reset; valid_q gates every use, so they can map to plain RAM.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            tag_q[idx_e] <= tag_e;
            if (taken_e) target_q[idx_e] <= TargetE;
        end
    end

    assign BranchCnt = branch_cnt_q;
    assign MissCnt   = miss_cnt_q;

endmodule
